// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch stage filling a DEPTH-entry {pc,instr} queue over a split-handshake ibus
// Optional FETCH_ADEL_EN: misaligned fetch_pc queues an address-error entry instead of a bus request.
package fetch_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            stale_q, stale_d;
    logic            adel_done_q, adel_done_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic            push, pop;
    logic [31:0]     push_pc, push_instr;
    logic [31:0]     redir_pc;
    logic            pc_misaligned;

`ifdef FETCH_ADEL_EN
    logic            adel_mem_q [DEPTH];
    logic            push_adel;
    assign redir_pc      = redirect_pc;
    assign pc_misaligned = fetch_pc_q[1:0] != 2'b00;
    assign out_adel      = adel_mem_q[head_q];
    localparam logic [31:0] RESET_PC_C = RESET_PC;
`else
    logic            unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_pc      = {redirect_pc[31:2], 2'b00};
    assign pc_misaligned = 1'b0;
    assign out_adel      = 1'b0;
    localparam logic [31:0] RESET_PC_C = {RESET_PC[31:2], 2'b00};
`endif

    assign out_valid = count_q != '0;
    assign out_pc    = pc_mem_q[head_q];
    assign out_instr = instr_mem_q[head_q];

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        stale_d     = stale_q;
        adel_done_d = adel_done_q;
        push        = 1'b0;
        push_pc     = req_addr_q;
        push_instr  = iresp.data;
`ifdef FETCH_ADEL_EN
        push_adel   = 1'b0;
`endif
        ireq.valid  = state_q == REQ;
        ireq.addr   = req_addr_q;

        case (state_q)
            IDLE: begin
                // count_q < DEPTH here reserves the slot for the response.
                if (!redirect_valid && count_q < DEPTH_C) begin
                    if (pc_misaligned) begin
                        if (!adel_done_q) begin
                            push        = 1'b1;
                            push_pc     = fetch_pc_q;
                            push_instr  = '0;
`ifdef FETCH_ADEL_EN
                            push_adel   = 1'b1;
`endif
                            adel_done_d = 1'b1;
                        end
                    end else begin
                        state_d    = REQ;
                        req_addr_d = fetch_pc_q;
                    end
                end
            end
            REQ: begin
                if (iresp.addr_ok) begin
                    stale_d = 1'b0;
                    if (redirect_valid || stale_q) begin
                        state_d = iresp.data_ok ? IDLE : DROP;
                    end else if (iresp.data_ok) begin
                        push       = 1'b1;
                        state_d    = IDLE;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (redirect_valid) begin
                    stale_d = 1'b1;
                end
            end
            WAIT: begin
                if (iresp.data_ok) begin
                    state_d = IDLE;
                    if (!redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (iresp.data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_d  = redir_pc;
            adel_done_d = 1'b0;
        end

        pop = out_valid & out_ready & ~redirect_valid;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = pop  ? head_q + AW'(1) : head_q;
            tail_d  = push ? tail_q + AW'(1) : tail_q;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC_C;
            req_addr_q  <= '0;
            stale_q     <= 1'b0;
            adel_done_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
`ifdef FETCH_ADEL_EN
                adel_mem_q[i]  <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            stale_q     <= stale_d;
            adel_done_q <= adel_done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            if (push) begin
                pc_mem_q[tail_q]    <= push_pc;
                instr_mem_q[tail_q] <= push_instr;
`ifdef FETCH_ADEL_EN
                adel_mem_q[tail_q]  <= push_adel;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (vector table, directed corners, random vs model)
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr;
    logic        out_adel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hbfc0_0000)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ireq(ireq), .iresp(iresp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
    );

    typedef struct {
        logic        ao;
        logic        dok;
        logic [31:0] d;
        logic        rdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_in;
    } vec_t;

    vec_t vt [10];

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return a ^ 32'h5a5a_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ao, input logic dok, input logic [31:0] d,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        iresp.addr_ok  = ao;
        iresp.data_ok  = dok;
        iresp.data     = d;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 32'h0, rdy, 1'b0, 32'h0);
    endtask

    // Ideal slave: accepts and answers in the same cycle as the request.
    task automatic auto_cycle(input logic rdy);
        drive(ireq.valid, ireq.valid, bus_word(ireq.addr), rdy, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(1'b0);
        idle(1'b0);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc, paddr, prev_addr, prev_pc, prev_in, rpc, d;
        logic        pend, prev_hold, prev_stall, ao, dok, rdy, redir, pop;
        int          n, pops;

        vt[0] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        vt[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hbfc0_0000, 1'b0, 32'h0,         32'h0};
        vt[2] = '{1'b0, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        vt[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0000, 32'h1111_0000};
        vt[4] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hbfc0_0004, 1'b0, 32'h0,         32'h0};
        vt[5] = '{1'b0, 1'b1, 32'h2222_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        vt[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0004, 32'h2222_0000};
        vt[7] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hbfc0_0008, 1'b0, 32'h0,         32'h0};
        vt[8] = '{1'b0, 1'b1, 32'h3333_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
        vt[9] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008, 32'h3333_0000};

        iresp = '0;
        do_reset();
        chk("reset_ireq_valid", ireq.valid, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_pc", out_pc, 32'h0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_adel", out_adel, 1'b0);

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d_ireq_valid", i), ireq.valid, vt[i].e_rv);
            if (vt[i].e_rv) chk($sformatf("vec%0d_ireq_addr", i), ireq.addr, vt[i].e_ra);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_out_instr", i), out_instr, vt[i].e_in);
            end
            drive(vt[i].ao, vt[i].dok, vt[i].d, vt[i].rdy, 1'b0, 32'h0);
        end

        // Back-pressure: exactly four entries, then one pop reopens fetch.
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ireq.valid) n++;
            auto_cycle(1'b0);
        end
        chk("fill_request_count", n, 4);
        chk("fill_stalled", ireq.valid, 1'b0);
        chk("fill_head_pc", out_pc, 32'hbfc0_0000);
        auto_cycle(1'b1);
        chk("after_pop_head_pc", out_pc, 32'hbfc0_0004);
        for (int i = 0; i < 5 && !ireq.valid; i++) idle(1'b0);
        chk("refetch_valid", ireq.valid, 1'b1);
        chk("refetch_addr", ireq.addr, 32'hbfc0_0010);

        // Redirect while waiting for data.
        do_reset();
        idle(1'b1);
        chk("wait_req_valid", ireq.valid, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000);
        chk("drop_no_req", ireq.valid, 1'b0);
        drive(1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 32'h0);
        chk("drop_no_push", out_valid, 1'b0);
        idle(1'b1);
        chk("wait_redir_req", ireq.valid, 1'b1);
        chk("wait_redir_addr", ireq.addr, 32'h8000_1000);
        chk("wait_redir_empty", out_valid, 1'b0);
        auto_cycle(1'b0);
        chk("wait_redir_pc", out_pc, 32'h8000_1000);
        chk("wait_redir_instr", out_instr, bus_word(32'h8000_1000));

        // Redirect while the request is not yet accepted.
        do_reset();
        idle(1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_2000);
        for (int i = 0; i < 3; i++) begin
            chk("req_hold_valid", ireq.valid, 1'b1);
            chk("req_hold_addr", ireq.addr, 32'hbfc0_0000);
            idle(1'b0);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("req_drop_no_req", ireq.valid, 1'b0);
        drive(1'b0, 1'b1, bus_word(32'hbfc0_0000), 1'b0, 1'b0, 32'h0);
        chk("req_drop_no_push", out_valid, 1'b0);
        idle(1'b0);
        chk("req_redir_addr", ireq.addr, 32'h8000_2000);
        auto_cycle(1'b0);
        chk("req_redir_pc", out_pc, 32'h8000_2000);

        // Redirect, pop and data_ok all in one cycle.
        do_reset();
        idle(1'b0);
        drive(1'b1, 1'b1, bus_word(32'hbfc0_0000), 1'b0, 1'b0, 32'h0);
        chk("triple_pre_valid", out_valid, 1'b1);
        idle(1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, bus_word(32'hbfc0_0004), 1'b1, 1'b1, 32'h8000_3000);
        chk("triple_empty", out_valid, 1'b0);
        idle(1'b0);
        chk("triple_req_addr", ireq.addr, 32'h8000_3000);
        auto_cycle(1'b0);
        chk("triple_pc", out_pc, 32'h8000_3000);

        // Misaligned redirect target.
        do_reset();
        idle(1'b0);
        drive(1'b1, 1'b1, bus_word(32'hbfc0_0000), 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0002);
`ifdef FETCH_ADEL_EN
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (ireq.valid) n++;
            idle(1'b0);
        end
        chk("adel_no_req", n, 0);
        chk("adel_valid", out_valid, 1'b1);
        chk("adel_pc", out_pc, 32'h8000_0002);
        chk("adel_instr", out_instr, 32'h0);
        chk("adel_flag", out_adel, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("adel_hold_valid", out_valid, 1'b0);
        chk("adel_hold_req", ireq.valid, 1'b0);
`else
        idle(1'b0);
        chk("misalign_req", ireq.valid, 1'b1);
        chk("misalign_addr", ireq.addr, 32'h8000_0000);
        auto_cycle(1'b0);
        chk("misalign_pc", out_pc, 32'h8000_0000);
        chk("misalign_adel", out_adel, 1'b0);
`endif

        // Random bus timing, back-pressure and redirects against a stream model.
        do_reset();
        exp_pc = 32'hbfc0_0000;
        pend = 1'b0; paddr = '0; prev_hold = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_in = '0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_hold) begin
                chk("rnd_req_held", ireq.valid, 1'b1);
                chk("rnd_req_addr_stable", ireq.addr, prev_addr);
            end
            if (pend) chk("rnd_one_inflight", ireq.valid, 1'b0);
            if (prev_stall) begin
                chk("rnd_out_stable_pc", out_pc, prev_pc);
                chk("rnd_out_stable_instr", out_instr, prev_in);
            end
            redir = $urandom_range(0, 99) < 3;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : $urandom;
`ifdef FETCH_ADEL_EN
            rpc[1:0] = 2'b00;
`endif
            rdy = $urandom_range(0, 99) < 60;
            ao = 1'b0; dok = 1'b0; d = '0;
            if (pend) begin
                if ($urandom_range(0, 99) < 40) begin
                    dok = 1'b1;
                    d = bus_word(paddr);
                end
            end else if (ireq.valid && $urandom_range(0, 1) == 1) begin
                ao = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    dok = 1'b1;
                    d = bus_word(ireq.addr);
                end
            end
            pop = out_valid & rdy & ~redir;
            if (pop) begin
                chk("rnd_pop_pc", out_pc, exp_pc);
                chk("rnd_pop_instr", out_instr, bus_word(exp_pc));
                chk("rnd_pop_adel", out_adel, 1'b0);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (redir) exp_pc = {rpc[31:2], 2'b00};
            if (ao && !dok) begin
                pend = 1'b1;
                paddr = ireq.addr;
            end else if (pend && dok) begin
                pend = 1'b0;
            end
            prev_hold  = ireq.valid && !ao;
            prev_addr  = ireq.addr;
            prev_stall = out_valid && !rdy && !redir;
            prev_pc    = out_pc;
            prev_in    = out_instr;
            drive(ao, dok, d, rdy, redir, rpc);
        end
        chk("rnd_liveness", pops >= 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
